// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizing for the SDRAM channel arbiter.
package sdram_arb_pkg;
    localparam int unsigned DEF_NPORT = 3;
    localparam int unsigned DEF_AW    = 25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_ACK
    } arb_state_t;
endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational grant picker: port 0 fixed priority, ports 1..NPORT-1 round-robin from i_ptr.
module sdram_arb_pick
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NPORT = DEF_NPORT,
    parameter int unsigned IW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic [NPORT-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic             o_valid,
    output logic [IW-1:0]    o_grant
);
    logic [31:0] w_dist;
    logic [31:0] w_best;

    always_comb begin
        o_valid = 1'b0;
        o_grant = '0;
        w_dist  = '0;
        w_best  = 32'(NPORT);
        // Closest requester at or after the pointer, measured cyclically over ports 1..NPORT-1.
        for (int unsigned c = 1; c < NPORT; c++) begin
            w_dist = (32'(c) + NPORT - 1 - 32'(i_ptr)) % (NPORT - 1);
            if (i_req[c] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_valid = 1'b1;
                o_grant = IW'(c);
            end
        end
        if (i_req[0]) begin
            o_valid = 1'b1;
            o_grant = '0;
        end
    end
endmodule

// File: rtl/sdram_ch_arbiter.sv
// Multi-port arbiter in front of a single-access SDRAM channel with edge-triggered strobes.
module sdram_ch_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NPORT = DEF_NPORT,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NPORT-1:0]    req,
    input  logic [NPORT-1:0]    we,
    input  logic [NPORT*AW-1:0] addr,
    input  logic [NPORT*8-1:0]  din,
    output logic [NPORT-1:0]    ack,
    output logic [7:0]          dout,
    output logic [AW-1:0]       sdram_addr,
    output logic                sdram_rd,
    output logic                sdram_wr,
    output logic [7:0]          sdram_din,
    input  logic [7:0]          sdram_dout,
    input  logic                sdram_busy
);
    localparam int unsigned IW = (NPORT > 1) ? $clog2(NPORT) : 1;

    arb_state_t    r_state;
    logic          r_we;
    logic [IW-1:0] r_grant;
    logic [IW-1:0] r_ptr;
    logic          w_valid;
    logic [IW-1:0] w_grant;

    sdram_arb_pick #(
        .NPORT (NPORT),
        .IW    (IW)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_grant (w_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_grant    <= '0;
            r_ptr      <= IW'(1);
            ack        <= '0;
            dout       <= '0;
            sdram_addr <= '0;
            sdram_din  <= '0;
            sdram_rd   <= 1'b0;
            sdram_wr   <= 1'b0;
        end else begin
            ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    // Busy gate also lets an access left over from before reset drain.
                    if (!sdram_busy && w_valid) begin
                        r_grant    <= w_grant;
                        r_we       <= we[w_grant];
                        sdram_addr <= addr[32'(w_grant) * AW +: AW];
                        sdram_din  <= din[32'(w_grant) * 8 +: 8];
                        if (w_grant != '0) begin
                            r_ptr <= (w_grant == IW'(NPORT - 1)) ? IW'(1) : w_grant + IW'(1);
                        end
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    sdram_rd <= ~r_we;
                    sdram_wr <= r_we;
                    r_state  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (sdram_busy) begin
                        sdram_rd <= 1'b0;
                        sdram_wr <= 1'b0;
                        r_state  <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!sdram_busy) begin
                        if (!r_we) begin
                            dout <= sdram_dout;
                        end
                        ack[r_grant] <= 1'b1;
                        r_state      <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_ch_arbiter.sv
// Randomized bench for sdram_ch_arbiter with a behavioural channel and arbitration model.
module tb_sdram_ch_arbiter;
    localparam int NPORT = 3;
    localparam int AW    = 25;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NPORT-1:0]    req = '0;
    logic [NPORT-1:0]    we = '0;
    logic [NPORT*AW-1:0] addr = '0;
    logic [NPORT*8-1:0]  din = '0;
    logic [NPORT-1:0]    ack;
    logic [7:0]          dout;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_rd;
    logic                sdram_wr;
    logic [7:0]          sdram_din;
    logic [7:0]          sdram_dout = '0;
    logic                sdram_busy = 1'b0;

    sdram_ch_arbiter #(.NPORT(NPORT), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .din        (din),
        .ack        (ack),
        .dout       (dout),
        .sdram_addr (sdram_addr),
        .sdram_rd   (sdram_rd),
        .sdram_wr   (sdram_wr),
        .sdram_din  (sdram_din),
        .sdram_dout (sdram_dout),
        .sdram_busy (sdram_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Channel model: an access starts on a strobe rising edge, busy follows after a delay.
    typedef struct {
        logic [AW-1:0] a;
        logic          w;
        logic [7:0]    d;
        logic [7:0]    rdata;
    } acc_t;

    acc_t       ch_q[$];
    acc_t       ch_r;
    int         ch_state = 0;
    int         ch_cnt = 0;
    int         ch_stall = -1;
    int         busy_len = -1;
    int         edge_cnt = 0;
    logic       ch_force = 1'b0;
    logic [7:0] ch_force_val = '0;
    logic [7:0] ch_rdata = '0;
    logic       ch_err = 1'b0;
    logic       prv_rd = 1'b0;
    logic       prv_wr = 1'b0;

    always @(negedge clk) begin
        if ((sdram_rd && !prv_rd) || (sdram_wr && !prv_wr)) begin
            edge_cnt++;
            if (ch_state != 0) ch_err = 1'b1;
            ch_r.a     = sdram_addr;
            ch_r.w     = sdram_wr;
            ch_r.d     = sdram_din;
            ch_r.rdata = ch_force ? ch_force_val : 8'($urandom);
            ch_force   = 1'b0;
            ch_rdata   = ch_r.rdata;
            ch_q.push_back(ch_r);
            ch_cnt   = (ch_stall >= 0) ? ch_stall : int'($urandom_range(0, 3));
            ch_state = 1;
        end else if (ch_state == 1) begin
            if (ch_cnt == 0) begin
                sdram_busy = 1'b1;
                sdram_dout = 8'($urandom);
                ch_cnt     = (busy_len >= 0) ? busy_len : int'($urandom_range(0, 4));
                ch_state   = 2;
            end else ch_cnt--;
        end else if (ch_state == 2) begin
            if (ch_cnt == 0) begin
                sdram_busy = 1'b0;
                sdram_dout = ch_rdata;
                ch_state   = 0;
            end else ch_cnt--;
        end
        prv_rd = sdram_rd;
        prv_wr = sdram_wr;
    end

    // Arbitration model: rotation list of non-zero ports, front = next in line.
    int            rr_q[$];
    int            remaining[NPORT];
    logic [AW-1:0] cur_a[NPORT];
    logic          cur_w[NPORT];
    logic [7:0]    cur_d[NPORT];
    logic [7:0]    exp_dout = '0;
    int            ack_cnt[NPORT];
    logic          force_read = 1'b0;

    task automatic model_reset();
        rr_q = {};
        for (int i = 1; i < NPORT; i++) rr_q.push_back(i);
        exp_dout = '0;
    endtask

    function automatic int model_pick();
        if (remaining[0] > 0) return 0;
        foreach (rr_q[i]) if (remaining[rr_q[i]] > 0) return rr_q[i];
        return -1;
    endfunction

    task automatic model_grant(input int p);
        if (p != 0) begin
            while (rr_q[0] != p) rr_q.push_back(rr_q.pop_front());
            rr_q.push_back(rr_q.pop_front());
        end
    endtask

    function automatic int total_remaining();
        int s = 0;
        for (int i = 0; i < NPORT; i++) s += remaining[i];
        return s;
    endfunction

    task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [7:0] d);
        cur_w[p] = w;
        cur_a[p] = a;
        cur_d[p] = d;
        we[p] = w;
        addr[p*AW +: AW] = a;
        din[p*8 +: 8] = d;
        req[p] = 1'b1;
    endtask

    task automatic new_random(input int p);
        set_port(p, force_read ? 1'b0 : 1'($urandom_range(0, 1)), AW'($urandom), 8'($urandom));
    endtask

    task automatic add_requests(input int p, input int n);
        remaining[p] = n;
        new_random(p);
    endtask

    task automatic run_traffic(input int budget, output int strobe_cycles);
        int   cyc = 0;
        int   sv_port = -1;
        int   p;
        logic both = 1'b0;
        logic early = 1'b0;
        acc_t r;
        strobe_cycles = 0;
        while (total_remaining() > 0 && cyc < budget) begin
            @(negedge clk); #1;
            cyc++;
            if (sdram_rd && sdram_wr) both = 1'b1;
            if (sdram_rd || sdram_wr) strobe_cycles++;
            if (ch_state == 1 && !(sdram_rd || sdram_wr)) early = 1'b1;
            if (sdram_busy && sv_port < 0) begin
                sv_port = model_pick();
                // Granted port now scribbles its inputs; the access must keep the latched values.
                if (sv_port >= 0) begin
                    addr[sv_port*AW +: AW] = ~cur_a[sv_port];
                    din[sv_port*8 +: 8] = ~cur_d[sv_port];
                end
            end
            if (ack != '0) begin
                p = -1;
                for (int i = NPORT - 1; i >= 0; i--) if (ack[i]) p = i;
                n_checks++; if (!$onehot(ack)) $display("FAIL ack_onehot: got %b want one-hot", ack); else n_pass++;
                n_checks++; if (p !== sv_port) $display("FAIL grant_order: got port %0d want port %0d", p, sv_port); else n_pass++;
                n_checks++; if (ch_state !== 0) $display("FAIL ack_after_busy: channel state %0d want 0", ch_state); else n_pass++;
                n_checks++;
                if (ch_q.size() != 1) $display("FAIL access_count: got %0d channel accesses want 1", ch_q.size());
                else begin
                    n_pass++;
                    r = ch_q.pop_front();
                    n_checks++; if (r.a !== cur_a[p] || r.w !== cur_w[p]) $display("FAIL access_cmd: got a=%h w=%b want a=%h w=%b", r.a, r.w, cur_a[p], cur_w[p]); else n_pass++;
                    if (cur_w[p]) begin
                        n_checks++; if (r.d !== cur_d[p]) $display("FAIL access_din: got %h want %h", r.d, cur_d[p]); else n_pass++;
                    end else exp_dout = r.rdata;
                end
                n_checks++; if (dout !== exp_dout) $display("FAIL dout: got %h want %h", dout, exp_dout); else n_pass++;
                ack_cnt[p]++;
                model_grant(p);
                remaining[p]--;
                if (remaining[p] > 0) new_random(p); else req[p] = 1'b0;
                sv_port = -1;
            end
        end
        n_checks++; if (cyc >= budget) $display("FAIL traffic_timeout: %0d requests left after %0d cycles, want 0", total_remaining(), cyc); else n_pass++;
        n_checks++; if (both || early || ch_err) $display("FAIL strobe_protocol: both=%b early_drop=%b edge_while_busy=%b want 0", both, early, ch_err); else n_pass++;
        for (int i = 0; i < NPORT; i++) begin
            remaining[i] = 0;
            req[i] = 1'b0;
        end
        repeat (4) @(negedge clk);
        #1;
        n_checks++; if (ack !== '0 || ch_q.size() != 0) $display("FAIL idle_after_traffic: ack=%b extra accesses=%0d want 0", ack, ch_q.size()); else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if ({ack, sdram_rd, sdram_wr} !== '0) $display("FAIL reset_strobes: ack=%b rd=%b wr=%b want 0", ack, sdram_rd, sdram_wr); else n_pass++;
        n_checks++; if (sdram_addr !== '0 || sdram_din !== '0 || dout !== '0) $display("FAIL reset_data: addr=%h din=%h dout=%h want 0", sdram_addr, sdram_din, dout); else n_pass++;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_read();
        int e0 = edge_cnt;
        int a0 = ack_cnt[1];
        int sc;
        ch_force = 1'b1;
        ch_force_val = 8'hA5;
        remaining[1] = 1;
        set_port(1, 1'b0, AW'('h0000101), 8'h11);
        run_traffic(500, sc);
        n_checks++; if (dout !== 8'hA5) $display("FAIL read_dout: got %h want a5", dout); else n_pass++;
        n_checks++; if (edge_cnt - e0 != 1 || ack_cnt[1] - a0 != 1) $display("FAIL read_once: edges=%0d acks=%0d want 1/1", edge_cnt - e0, ack_cnt[1] - a0); else n_pass++;
    endtask

    task automatic test_single_write();
        int sc;
        remaining[0] = 1;
        set_port(0, 1'b1, AW'('h1FFFFFF), 8'h3C);
        run_traffic(500, sc);
        n_checks++; if (sdram_addr !== AW'('h1FFFFFF) || sdram_din !== 8'h3C) $display("FAIL write_regs: addr=%h din=%h want 1ffffff/3c", sdram_addr, sdram_din); else n_pass++;
        n_checks++; if (dout !== 8'hA5) $display("FAIL write_dout_held: got %h want a5", dout); else n_pass++;
    endtask

    task automatic test_contention();
        int sc;
        for (int round = 0; round < 4; round++) begin
            for (int p = 0; p < NPORT; p++) add_requests(p, int'($urandom_range(round == 0 ? 1 : 0, 4)));
            for (int p = 0; p < NPORT; p++) if (remaining[p] == 0) req[p] = 1'b0;
            run_traffic(3000, sc);
        end
    endtask

    task automatic test_init_stall();
        int sc;
        ch_stall = 40;
        force_read = 1'b1;
        add_requests(2, 1);
        run_traffic(500, sc);
        ch_stall = -1;
        force_read = 1'b0;
        n_checks++; if (sc < 41) $display("FAIL stall_strobe_held: strobe high %0d cycles want >= 41", sc); else n_pass++;
    endtask

    task automatic test_reset_midaccess();
        int   cyc = 0;
        int   sc;
        logic bad = 1'b0;
        busy_len = 20;
        force_read = 1'b1;
        add_requests(1, 1);
        while (!(sdram_busy && !sdram_rd) && cyc < 60) begin
            @(negedge clk); #1;
            cyc++;
        end
        n_checks++; if (cyc >= 60) $display("FAIL reach_wait_done: busy=%b rd=%b want 1/0", sdram_busy, sdram_rd); else n_pass++;
        reset = 1'b1;
        @(negedge clk); #1;
        n_checks++; if ({ack, sdram_rd, sdram_wr} !== '0) $display("FAIL midreset_strobes: ack=%b rd=%b wr=%b want 0", ack, sdram_rd, sdram_wr); else n_pass++;
        @(negedge clk); #1;
        reset = 1'b0;
        model_reset();
        n_checks++; if (ack !== '0 || dout !== '0) $display("FAIL midreset_outputs: ack=%b dout=%h want 0", ack, dout); else n_pass++;
        busy_len = -1;
        cyc = 0;
        while (sdram_busy && cyc < 60) begin
            @(negedge clk); #1;
            cyc++;
            if (sdram_rd || sdram_wr || ack != '0) bad = 1'b1;
        end
        n_checks++; if (bad || cyc >= 60) $display("FAIL drain_before_grant: activity=%b busy=%b want 0/0", bad, sdram_busy); else n_pass++;
        ch_q.delete();
        run_traffic(500, sc);
        force_read = 1'b0;
    endtask

    task automatic test_back_to_back();
        int e0 = edge_cnt;
        int a0 = ack_cnt[2];
        int sc;
        force_read = 1'b1;
        add_requests(2, 3);
        run_traffic(1000, sc);
        force_read = 1'b0;
        n_checks++; if (ack_cnt[2] - a0 != 3 || edge_cnt - e0 != 3) $display("FAIL b2b_count: acks=%0d edges=%0d want 3/3", ack_cnt[2] - a0, edge_cnt - e0); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < NPORT; i++) begin
            remaining[i] = 0;
            ack_cnt[i] = 0;
        end
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_init_stall();
        test_reset_midaccess();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
